// File: rtl/multicycle_control.sv
// Multicycle RV-style control unit: one FSM walks each instruction through
// fetch, decode, execute / memory / branch and write-back, and drives the
// datapath enables and mux selects from the current state.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_addr_sel,
  output logic       wb_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic       pc_src,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_TRAP     = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  state_t cur;
  state_t nxt;

  logic is_ld;
  logic is_sd;
  logic is_r;
  logic is_i;
  logic is_beq;
  logic alu_legal;
  logic [3:0] alu_dec;

  // ALU operation for R/I-type; SUB only exists in the register form
  function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                            input logic       f7_5,
                                            input logic       rtype);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = (rtype && f7_5) ? ALU_SUB : ALU_ADD;
      3'b111:  op = ALU_AND;
      3'b110:  op = ALU_OR;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  assign is_ld     = (opcode == OP_LOAD)   && (funct3 == 3'b011);
  assign is_sd     = (opcode == OP_STORE)  && (funct3 == 3'b011);
  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_beq    = (opcode == OP_BRANCH) && (funct3 == 3'b000);
  assign alu_legal = (funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110);
  assign alu_dec   = alu_decode(funct3, funct7_5, is_r);
  assign state     = cur;

  // Next-state selection; encodings outside the defined set fall into TRAP
  always_comb begin
    nxt = S_TRAP;
    case (cur)
      S_FETCH:    nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_ld || is_sd)     nxt = S_MEM_ADDR;
        else if (is_r || is_i)  nxt = S_EXEC;
        else if (is_beq)        nxt = S_BRANCH;
        else                    nxt = S_TRAP;
      end
      S_MEM_ADDR: nxt = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   nxt = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   nxt = S_FETCH;
      S_MEM_WR:   nxt = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC:     nxt = alu_legal ? S_ALU_WB : S_TRAP;
      S_ALU_WB:   nxt = S_FETCH;
      S_BRANCH:   nxt = S_FETCH;
      S_TRAP:     nxt = S_TRAP;
      default:    nxt = S_TRAP;
    endcase
  end

  // State register and sticky illegal flag; reset overrides every transition
  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt == S_TRAP) illegal <= 1'b1;
    end
  end

  // Datapath controls decoded from the current state (plus handshake/zero)
  always_comb begin
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    mem_addr_sel = 1'b0;
    wb_sel       = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = ALU_ADD;
    pc_src       = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
        end
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read     = 1'b1;
        mem_addr_sel = 1'b1;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        wb_sel    = 1'b1;
      end
      S_MEM_WR: begin
        mem_write    = 1'b1;
        mem_addr_sel = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = is_i ? 2'b10 : 2'b00;
        alu_op    = alu_legal ? alu_dec : ALU_ADD;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 1'b1;
        pc_write  = zero;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each scenario queues per-cycle stimulus and
// the expected state/control word, then replays and compares cycle by cycle.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write;
  logic       mem_addr_sel, wb_sel, alu_src_a, pc_src, illegal;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic rst;
    logic rdy;
    logic z;
  } stim_t;

  stim_t       stim_q[$];
  logic [19:0] exp_q[$];
  logic [19:0] obs;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .mem_addr_sel(mem_addr_sel),
    .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {state, pc_write, ir_write, mem_read, mem_write, reg_write,
                mem_addr_sel, wb_sel, alu_src_a, alu_src_b, alu_op, pc_src, illegal};

  // Expected word: state, pcw, irw, mr, mw, rw, mas, wbs, asa, asb, aop, psrc, ill
  function automatic logic [19:0] mk(input logic [3:0] st, input logic pcw,
      input logic irw, input logic mr, input logic mw, input logic rw,
      input logic mas, input logic wbs, input logic asa, input logic [1:0] asb,
      input logic [3:0] aop, input logic psrc, input logic ill);
    return {st, pcw, irw, mr, mw, rw, mas, wbs, asa, asb, aop, psrc, ill};
  endfunction

  function automatic logic [19:0] e_fetch(input logic rdy);
    return mk(4'd0, rdy, rdy, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              rdy ? 2'b01 : 2'b00, 4'b0010, 1'b0, 1'b0);
  endfunction
  function automatic logic [19:0] e_idle(input logic [3:0] st, input logic ill);
    return mk(st, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0010, 0, ill);
  endfunction
  function automatic logic [19:0] e_exec(input logic [1:0] asb, input logic [3:0] aop);
    return mk(4'd6, 0, 0, 0, 0, 0, 0, 0, 1, asb, aop, 0, 0);
  endfunction

  task automatic push(input logic rst, input logic rdy, input logic z, input logic [19:0] e);
    stim_q.push_back('{rst: rst, rdy: rdy, z: z});
    exp_q.push_back(e);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    opcode = op; funct3 = f3; funct7_5 = f75;
  endtask

  // Drive one cycle's inputs, capture the combinational outputs, advance
  task automatic run_cycle(input stim_t s, output logic [19:0] o);
    reset = s.rst; mem_ready = s.rdy; zero = s.z;
    #1;
    o = obs;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [19:0] o, e;
    stim_t s;
    int i = 0;
    push(0, 0, 0, e_fetch(0));
    push(1, 1, 1, e_fetch(1));
    push(0, 0, 0, e_fetch(0));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); run_cycle(s, o); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL reset c%0d: got %h want %h", i, o, e); end
      i++;
    end
  endtask

  task automatic test_alu_ops();
    logic [19:0] o, e;
    stim_t s;
    logic [6:0] ops [7] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
                            7'b0010011, 7'b0010011, 7'b0010011};
    logic [2:0] f3s [7] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b000, 3'b111, 3'b110};
    logic       f7s [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] asb [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10};
    logic [3:0] aop [7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0001};
    for (int k = 0; k < 7; k++) begin
      int i = 0;
      set_instr(ops[k], f3s[k], f7s[k]);
      push(0, 1, 0, e_fetch(1));
      push(0, 1, 0, e_idle(4'd1, 0));
      push(0, 1, 0, e_exec(asb[k], aop[k]));
      push(0, 1, 0, mk(4'd7, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 4'b0010, 0, 0));
      while (exp_q.size() > 0) begin
        s = stim_q.pop_front(); run_cycle(s, o); e = exp_q.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL alu%0d c%0d: got %h want %h", k, i, o, e); end
        i++;
      end
    end
  endtask

  task automatic test_load_stall();
    logic [19:0] o, e;
    stim_t s;
    int i = 0;
    set_instr(7'b0000011, 3'b011, 1'b0);
    push(0, 0, 0, e_fetch(0));
    push(0, 1, 0, e_fetch(1));
    push(0, 0, 0, e_idle(4'd1, 0));
    push(0, 1, 0, mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'b0010, 0, 0));
    for (int k = 0; k < 3; k++)
      push(0, 0, 0, mk(4'd3, 0, 0, 1, 0, 0, 1, 0, 0, 2'b00, 4'b0010, 0, 0));
    push(0, 1, 0, mk(4'd3, 0, 0, 1, 0, 0, 1, 0, 0, 2'b00, 4'b0010, 0, 0));
    push(0, 1, 0, mk(4'd4, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 4'b0010, 0, 0));
    push(0, 1, 0, e_fetch(1));
    // second load aborted by reset in MEM_RD: no write-back follows
    push(0, 1, 0, e_idle(4'd1, 0));
    push(0, 1, 0, mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'b0010, 0, 0));
    push(1, 1, 0, mk(4'd3, 0, 0, 1, 0, 0, 1, 0, 0, 2'b00, 4'b0010, 0, 0));
    push(0, 0, 0, e_fetch(0));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); run_cycle(s, o); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL ld c%0d: got %h want %h", i, o, e); end
      i++;
    end
  endtask

  task automatic test_store_reset();
    logic [19:0] o, e;
    stim_t s;
    int i = 0;
    logic [19:0] wr;
    wr = mk(4'd5, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 4'b0010, 0, 0);
    set_instr(7'b0100011, 3'b011, 1'b0);
    push(0, 1, 0, e_fetch(1));
    push(0, 0, 0, e_idle(4'd1, 0));
    push(0, 0, 0, mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'b0010, 0, 0));
    push(0, 1, 0, wr);
    push(0, 1, 0, e_fetch(1));
    push(0, 1, 0, e_idle(4'd1, 0));
    push(0, 1, 0, mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'b0010, 0, 0));
    push(0, 0, 0, wr);
    push(1, 0, 0, wr);
    push(0, 0, 0, e_fetch(0));
    push(0, 0, 0, e_fetch(0));
    push(0, 1, 0, e_fetch(1));
    push(0, 1, 0, e_idle(4'd1, 0));
    push(0, 1, 0, mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'b0010, 0, 0));
    push(0, 1, 0, wr);
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); run_cycle(s, o); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL sd c%0d: got %h want %h", i, o, e); end
      i++;
    end
  endtask

  task automatic test_branch();
    logic [19:0] o, e;
    stim_t s;
    int i = 0;
    set_instr(7'b1100011, 3'b000, 1'b0);
    for (int k = 0; k < 2; k++) begin
      logic z = (k == 0);
      push(0, 1, z, e_fetch(1));
      push(0, 1, z, e_idle(4'd1, 0));
      push(0, 1, z, mk(4'd8, z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0110, 1, 0));
    end
    push(0, 0, 0, e_fetch(0));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); run_cycle(s, o); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL beq c%0d: got %h want %h", i, o, e); end
      i++;
    end
  endtask

  task automatic test_trap();
    logic [19:0] o, e;
    stim_t s;
    int i = 0;
    // unknown opcode traps straight out of DECODE and holds through mem_ready/zero noise
    set_instr(7'b1111111, 3'b000, 1'b0);
    push(0, 1, 0, e_fetch(1));
    push(0, 1, 0, e_idle(4'd1, 0));
    for (int k = 0; k < 12; k++)
      push(0, k[0], k[1], e_idle(4'd9, 1));
    push(1, 1, 1, e_idle(4'd9, 1));
    push(0, 0, 0, e_fetch(0));
    // ld with a bad funct3 traps from DECODE
    set_instr(7'b0000011, 3'b010, 1'b0);
    push(0, 1, 0, e_fetch(1));
    push(0, 1, 0, e_idle(4'd1, 0));
    push(0, 1, 0, e_idle(4'd9, 1));
    push(1, 0, 0, e_idle(4'd9, 1));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); run_cycle(s, o); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL trap c%0d: got %h want %h", i, o, e); end
      i++;
    end
    // R-type with unsupported funct3 only traps after EXEC
    i = 0;
    set_instr(7'b0110011, 3'b001, 1'b0);
    push(0, 1, 0, e_fetch(1));
    push(0, 1, 0, e_idle(4'd1, 0));
    push(0, 1, 0, e_exec(2'b00, 4'b0010));
    push(0, 1, 0, e_idle(4'd9, 1));
    push(1, 1, 0, e_idle(4'd9, 1));
    push(0, 0, 0, e_fetch(0));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); run_cycle(s, o); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL exectrap c%0d: got %h want %h", i, o, e); end
      i++;
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_alu_ops();
    test_load_stall();
    test_store_reset();
    test_branch();
    test_trap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
